// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and write-port source select for the regfile arbiter
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MD
  } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write bits with two combinational read ports
module rf_scoreboard #(
  parameter int NREG   = regfile_pkg::NREG,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  input  logic [ADDR_W-1:0] rd0_idx_i,
  output logic              rd0_busy_o,
  input  logic [ADDR_W-1:0] rd1_idx_i,
  output logic              rd1_busy_o
);
  import regfile_pkg::*;

  logic [NREG-1:0] sb_q, sb_d;

  // Set is applied after clear so a same-index set/clear leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (clr_i) sb_d[clr_idx_i] = 1'b0;
    if (set_i && (set_idx_i != '0)) sb_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign rd0_busy_o = (rd0_idx_i != '0) && sb_q[rd0_idx_i];
  assign rd1_busy_o = (rd1_idx_i != '0) && sb_q[rd1_idx_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the regfile write port between pipeline WB and mul/div results
module regfile_wb_arbiter #(
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int ADDR_W     = regfile_pkg::ADDR_W,
  parameter int NREG       = regfile_pkg::NREG,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              md_issue,
  input  logic [ADDR_W-1:0] md_issue_rd,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall_req,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData
);
  import regfile_pkg::*;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_rd_q, buf_rd_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              stall_q, stall_d;
  logic              pipe_wr, accept, drain, blocked;
  wb_src_e           src;

  assign pipe_wr   = pipe_we && (pipe_waddr != '0);
  assign drain     = buf_valid_q && !pipe_wr;
  assign blocked   = buf_valid_q && pipe_wr;
  assign md_ready  = rst_n && !buf_valid_q;
  assign accept    = md_valid && md_ready;
  assign stall_req = stall_q;

  always_comb begin
    src = SRC_NONE;
    if (pipe_wr) src = SRC_PIPE;
    else if (buf_valid_q && (buf_rd_q != '0)) src = SRC_MD;
  end

  always_comb begin
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    if (rst_n) begin
      case (src)
        SRC_PIPE: begin
          RegWrite  = 1'b1;
          WriteReg  = pipe_waddr;
          WriteData = pipe_wdata;
        end
        SRC_MD: begin
          RegWrite  = 1'b1;
          WriteReg  = buf_rd_q;
          WriteData = buf_data_q;
        end
        default: ;
      endcase
    end
  end

  // Drain and accept never coincide: accept needs an empty buffer.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    cnt_d       = '0;
    stall_d     = 1'b0;
    if (drain) buf_valid_d = 1'b0;
    if (accept) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = md_rd;
      buf_data_d  = md_data;
    end
    if (blocked) begin
      if (cnt_q + 4'd1 == STARVE_LIM) stall_d = 1'b1;
      else                           cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
    end
  end

  rf_scoreboard #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (md_issue),
    .set_idx_i  (md_issue_rd),
    .clr_i      (drain),
    .clr_idx_i  (buf_rd_q),
    .rd0_idx_i  (rs_addr),
    .rd0_busy_o (rs_busy),
    .rd1_idx_i  (rt_addr),
    .rd1_busy_o (rt_busy)
  );

endmodule
